// File: rtl/counter_timer_core.sv
// General-purpose counter/timer: periodic or oneshot, up or down, chainable
// into a wider timer through chain_in/chain_out, with a one-cycle terminal irq.
module counter_timer_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [4:0]       cfg_di,
    output logic [4:0]       cfg_do,
    input  logic             val_we,
    input  logic [WIDTH-1:0] val_di,
    output logic [WIDTH-1:0] val_do,
    input  logic             dat_we,
    input  logic [WIDTH-1:0] dat_di,
    output logic [WIDTH-1:0] dat_do,
    input  logic             chain_in,
    output logic             chain_out,
    output logic             irq
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [4:0]       r_cfg;
    logic [WIDTH-1:0] r_val;
    logic [WIDTH-1:0] r_dat;
    logic             r_irq;

    logic             w_enable;
    logic             w_oneshot;
    logic             w_up;
    logic             w_chain;
    logic             w_irq_en;
    logic             w_tick;
    logic             w_term;
    logic             w_term_tick;
    logic [WIDTH-1:0] w_dat_next;

    assign w_enable  = r_cfg[0];
    assign w_oneshot = r_cfg[1];
    assign w_up      = r_cfg[2];
    assign w_chain   = r_cfg[3];
    assign w_irq_en  = r_cfg[4];

    // A chained stage only advances when the lower stage reports terminal count.
    assign w_tick      = w_enable & (~w_chain | chain_in);
    assign w_term      = w_up ? (r_dat == r_val) : (r_dat == ZERO);
    assign w_term_tick = w_tick & w_term;

    always_comb begin
        w_dat_next = r_dat;
        if (!w_term) begin
            w_dat_next = w_up ? (r_dat + ONE) : (r_dat - ONE);
        end else if (!w_oneshot) begin
            w_dat_next = w_up ? ZERO : r_val;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cfg <= 5'd0;
            r_val <= ZERO;
            r_dat <= ZERO;
            r_irq <= 1'b0;
        end else begin
            // Software writes always win over hardware updates in the same cycle.
            if (cfg_we) begin
                r_cfg <= cfg_di;
            end else if (w_term_tick && w_oneshot) begin
                r_cfg[0] <= 1'b0;
            end

            if (val_we) begin
                r_val <= val_di;
            end

            if (dat_we) begin
                r_dat <= dat_di;
            end else if (w_tick) begin
                r_dat <= w_dat_next;
            end

            r_irq <= w_term_tick & w_irq_en;
        end
    end

    assign cfg_do    = r_cfg;
    assign val_do    = r_val;
    assign dat_do    = r_dat;
    assign chain_out = w_term_tick;
    assign irq       = r_irq;

endmodule

// File: tb/tb_counter_timer_core.sv
// Directed bench for counter_timer_core: a standalone stage plus a chained
// upper stage, checked cycle by cycle against hand-computed values.
module tb_counter_timer_core;

    localparam int W = 32;
    localparam int SEL_CFG = 0;
    localparam int SEL_VAL = 1;
    localparam int SEL_DAT = 2;

    logic         clk;
    logic         resetn;

    logic         lo_cfg_we, lo_val_we, lo_dat_we, lo_chain_in;
    logic [4:0]   lo_cfg_di;
    logic [W-1:0] lo_val_di, lo_dat_di;
    logic [4:0]   lo_cfg_do;
    logic [W-1:0] lo_val_do, lo_dat_do;
    logic         lo_chain_out, lo_irq;

    logic         hi_cfg_we, hi_val_we, hi_dat_we;
    logic [4:0]   hi_cfg_di;
    logic [W-1:0] hi_val_di, hi_dat_di;
    logic [4:0]   hi_cfg_do;
    logic [W-1:0] hi_val_do, hi_dat_do;
    logic         hi_chain_out, hi_irq;

    int checks;
    int failures;
    int irq_pulses;

    counter_timer_core #(.WIDTH(W)) u_lo (
        .clk(clk), .resetn(resetn),
        .cfg_we(lo_cfg_we), .cfg_di(lo_cfg_di), .cfg_do(lo_cfg_do),
        .val_we(lo_val_we), .val_di(lo_val_di), .val_do(lo_val_do),
        .dat_we(lo_dat_we), .dat_di(lo_dat_di), .dat_do(lo_dat_do),
        .chain_in(lo_chain_in), .chain_out(lo_chain_out), .irq(lo_irq)
    );

    counter_timer_core #(.WIDTH(W)) u_hi (
        .clk(clk), .resetn(resetn),
        .cfg_we(hi_cfg_we), .cfg_di(hi_cfg_di), .cfg_do(hi_cfg_do),
        .val_we(hi_val_we), .val_di(hi_val_di), .val_do(hi_val_do),
        .dat_we(hi_dat_we), .dat_di(hi_dat_di), .dat_do(hi_dat_do),
        .chain_in(lo_chain_out), .chain_out(hi_chain_out), .irq(hi_irq)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // All driving happens 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int unit, input int sel, input logic [W-1:0] d);
        if (unit == 0) begin
            lo_cfg_we = (sel == SEL_CFG); lo_cfg_di = d[4:0];
            lo_val_we = (sel == SEL_VAL); lo_val_di = d;
            lo_dat_we = (sel == SEL_DAT); lo_dat_di = d;
        end else begin
            hi_cfg_we = (sel == SEL_CFG); hi_cfg_di = d[4:0];
            hi_val_we = (sel == SEL_VAL); hi_val_di = d;
            hi_dat_we = (sel == SEL_DAT); hi_dat_di = d;
        end
        step();
        lo_cfg_we = 1'b0; lo_val_we = 1'b0; lo_dat_we = 1'b0;
        hi_cfg_we = 1'b0; hi_val_we = 1'b0; hi_dat_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        irq_pulses = 0;
        resetn = 1'b0;
        lo_cfg_we = 1'b0; lo_val_we = 1'b0; lo_dat_we = 1'b0; lo_chain_in = 1'b0;
        lo_cfg_di = '0; lo_val_di = '0; lo_dat_di = '0;
        hi_cfg_we = 1'b0; hi_val_we = 1'b0; hi_dat_we = 1'b0;
        hi_cfg_di = '0; hi_val_di = '0; hi_dat_di = '0;
        step();
        step();
        resetn = 1'b1;
        step();

        check("rst_cfg", lo_cfg_do, 0);
        check("rst_val", lo_val_do, 0);
        check("rst_dat", lo_dat_do, 0);
        check("rst_irq", lo_irq, 0);
        check("rst_chain", lo_chain_out, 0);

        // 1. down-count periodic, val=0x11, irq every 18 cycles
        wr(0, SEL_VAL, 32'h11);
        wr(0, SEL_DAT, 32'h11);
        wr(0, SEL_CFG, 32'h11);
        for (int k = 0; k <= 36; k++) begin
            check("p1_dat", lo_dat_do, 32'h11 - (k % 18));
            check("p1_irq", lo_irq, (k != 0 && (k % 18) == 0) ? 1 : 0);
            check("p1_chain", lo_chain_out, ((k % 18) == 17) ? 1 : 0);
            if (lo_irq) irq_pulses++;
            if (k < 36) step();
        end
        check("p1_irq_pulses", irq_pulses, 2);

        // 2. oneshot down, val=0x0f
        wr(0, SEL_CFG, 0);
        wr(0, SEL_VAL, 32'h0f);
        wr(0, SEL_DAT, 32'h0f);
        wr(0, SEL_CFG, 32'h03);
        for (int k = 0; k < 20; k++) begin
            check("p2_dat", lo_dat_do, (k < 15) ? (15 - k) : 0);
            check("p2_cfg", lo_cfg_do, (k <= 15) ? 5'h03 : 5'h02);
            check("p2_irq", lo_irq, 0);
            step();
        end

        // 3. up-count, limit 0x0f
        wr(0, SEL_CFG, 0);
        wr(0, SEL_VAL, 32'h0f);
        wr(0, SEL_DAT, 0);
        wr(0, SEL_CFG, 32'h05);
        for (int k = 0; k <= 33; k++) begin
            check("p3_dat", lo_dat_do, k % 16);
            check("p3_chain", lo_chain_out, ((k % 16) == 15) ? 1 : 0);
            check("p3_irq", lo_irq, 0);
            if (k < 33) step();
        end

        // 4a. dat write collides with a tick
        wr(0, SEL_DAT, 32'h12b4);
        check("p4_dat_wr", lo_dat_do, 32'h12b4);
        step();
        check("p4_dat_after", lo_dat_do, 32'h12b5);

        // 4b. cfg write on the oneshot terminal edge keeps enable set
        wr(0, SEL_CFG, 0);
        wr(0, SEL_VAL, 3);
        wr(0, SEL_DAT, 3);
        wr(0, SEL_CFG, 32'h03);
        step(); step(); step();
        check("p4_term_dat", lo_dat_do, 0);
        check("p4_term_chain", lo_chain_out, 1);
        wr(0, SEL_CFG, 32'h03);
        check("p4_cfg_kept", lo_cfg_do, 5'h03);
        check("p4_dat_hold", lo_dat_do, 0);
        step();
        check("p4_cfg_clr", lo_cfg_do, 5'h02);
        check("p4_dat_hold2", lo_dat_do, 0);

        // writes alone raise neither irq nor chain_out
        wr(0, SEL_CFG, 0);
        wr(0, SEL_DAT, 0);
        check("wr_no_chain", lo_chain_out, 0);
        step();
        check("wr_no_irq", lo_irq, 0);

        // 5. chained 64-bit
        wr(1, SEL_VAL, 32'hffffffff);
        wr(1, SEL_DAT, 32'h55);
        wr(1, SEL_CFG, 32'h09);
        wr(0, SEL_VAL, 32'hffffffff);
        wr(0, SEL_DAT, 32'h2);
        wr(0, SEL_CFG, 32'h01);
        for (int k = 0; k <= 5; k++) begin
            logic [W-1:0] exp_lo;
            case (k)
                0: exp_lo = 32'h2;
                1: exp_lo = 32'h1;
                2: exp_lo = 32'h0;
                3: exp_lo = 32'hffffffff;
                4: exp_lo = 32'hfffffffe;
                default: exp_lo = 32'hfffffffd;
            endcase
            check("p5_lo_dat", lo_dat_do, exp_lo);
            check("p5_lo_chain", lo_chain_out, (k == 2) ? 1 : 0);
            check("p5_hi_dat", hi_dat_do, (k >= 3) ? 32'h54 : 32'h55);
            check("p5_hi_irq", hi_irq, 0);
            if (k < 5) step();
        end

        // 6. async reset mid-count with irq pending
        wr(0, SEL_CFG, 0);
        wr(0, SEL_VAL, 0);
        wr(0, SEL_DAT, 0);
        wr(0, SEL_CFG, 32'h11);
        step(); step();
        check("p6_irq_pending", lo_irq, 1);
        #2 resetn = 1'b0;
        #1;
        check("p6_rst_cfg", lo_cfg_do, 0);
        check("p6_rst_val", lo_val_do, 0);
        check("p6_rst_dat", lo_dat_do, 0);
        check("p6_rst_irq", lo_irq, 0);
        check("p6_rst_chain", lo_chain_out, 0);
        check("p6_rst_hi_dat", hi_dat_do, 0);
        check("p6_rst_hi_cfg", hi_cfg_do, 0);
        step(); step();
        resetn = 1'b1;
        step(); step(); step();
        check("p6_idle_dat", lo_dat_do, 0);
        check("p6_idle_cfg", lo_cfg_do, 0);
        check("p6_idle_irq", lo_irq, 0);
        wr(0, SEL_DAT, 5);
        step(); step(); step();
        check("p6_no_count", lo_dat_do, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
